reg_file_write_arbiter: RTL and testbench

REG_FILE_WRITE_ARBITER -- requirements
Module: reg_file_write_arbiter

---
 rtl/reg_file_write_arbiter.sv | 124 ++++++++++++
 tb/tb_reg_file_write_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_write_arbiter.sv
// Register-file write port shared by two requesters: clears every entry after
// reset, then grants one write per cycle with round-robin on contention.
module reg_file_write_arbiter #(
  parameter  int unsigned REG_WIDTH = 9,
  parameter  int unsigned NUM_REGS  = 16,
  localparam int unsigned ADDR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [REG_WIDTH-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [REG_WIDTH-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 rf_write,
  output logic [ADDR_W-1:0]    rf_addr,
  output logic [REG_WIDTH-1:0] rf_data,
  output logic                 init_done
);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_ARB  = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  logic [0:0]           r_state;
  logic [ADDR_W-1:0]    r_cnt;
  logic                 r_ptr;
  logic                 r_rf_write;
  logic [ADDR_W-1:0]    r_rf_addr;
  logic [REG_WIDTH-1:0] r_rf_data;
  logic                 r_init_done;

  logic [0:0]           w_state_nxt;
  logic [ADDR_W-1:0]    w_cnt_nxt;
  logic                 w_ptr_nxt;
  logic                 w_rf_write_nxt;
  logic [ADDR_W-1:0]    w_rf_addr_nxt;
  logic [REG_WIDTH-1:0] w_rf_data_nxt;
  logic                 w_init_done_nxt;
  logic                 w_arb_en;
  logic                 w_gnt0;
  logic                 w_gnt1;

  // Grant decode; r_ptr names the requester that wins a tie.
  always_comb begin
    w_arb_en = (r_state == S_ARB) && !hold;
    w_gnt0   = w_arb_en && req0_valid && (!req1_valid || !r_ptr);
    w_gnt1   = w_arb_en && req1_valid && (!req0_valid ||  r_ptr);
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_ptr_nxt       = r_ptr;
    w_rf_write_nxt  = 1'b0;
    w_rf_addr_nxt   = r_rf_addr;
    w_rf_data_nxt   = r_rf_data;
    w_init_done_nxt = r_init_done;
    case (r_state)
      S_INIT: begin
        w_rf_write_nxt = 1'b1;
        w_rf_addr_nxt  = r_cnt;
        w_rf_data_nxt  = REG_WIDTH'(0);
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt     = S_ARB;
          w_init_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      S_ARB: begin
        if (w_gnt0) begin
          w_rf_write_nxt = 1'b1;
          w_rf_addr_nxt  = req0_addr;
          w_rf_data_nxt  = req0_data;
          w_ptr_nxt      = 1'b1;
        end else if (w_gnt1) begin
          w_rf_write_nxt = 1'b1;
          w_rf_addr_nxt  = req1_addr;
          w_rf_data_nxt  = req1_data;
          w_ptr_nxt      = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_ptr       <= 1'b0;
      r_rf_write  <= 1'b0;
      r_rf_addr   <= '0;
      r_rf_data   <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ptr       <= w_ptr_nxt;
      r_rf_write  <= w_rf_write_nxt;
      r_rf_addr   <= w_rf_addr_nxt;
      r_rf_data   <= w_rf_data_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  assign rf_write  = r_rf_write;
  assign rf_addr   = r_rf_addr;
  assign rf_data   = r_rf_data;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Directed bench for reg_file_write_arbiter: expected writes queued at issue,
// popped and compared by a monitor whenever rf_write is seen.
module tb_reg_file_write_arbiter;

  logic       clk;
  logic       rst_n;
  logic       hold;
  logic       req0_valid;
  logic [3:0] req0_addr;
  logic [8:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [3:0] req1_addr;
  logic [8:0] req1_data;
  logic       req1_ready;
  logic       rf_write;
  logic [3:0] rf_addr;
  logic [8:0] rf_data;
  logic       init_done;

  typedef struct packed {
    logic [3:0] a;
    logic [8:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  reg_file_write_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (hold),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_write   (rf_write),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [8:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 16; i++) push(4'(i), 9'h000);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_rf_write"},  32'(rf_write),  32'd0);
    chk({name, "_rf_addr"},   32'(rf_addr),   32'd0);
    chk({name, "_rf_data"},   32'(rf_data),   32'd0);
    chk({name, "_init_done"}, 32'(init_done), 32'd0);
    chk({name, "_readies"},   32'({req1_ready, req0_ready}), 32'd0);
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (rf_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'({rf_addr, rf_data}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(rf_addr), 32'(e.a));
          chk("wr_data", 32'(rf_data), 32'(e.d));
        end
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    hold       = 1'b0;
    req0_valid = 1'b1;
    req0_addr  = '0;
    req0_data  = '0;
    req1_valid = 1'b1;
    req1_addr  = '0;
    req1_data  = '0;
    fork
      monitor();
    join_none

    // Reset state, with both valids high.
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");

    // Clear sweep: 16 writes of zero, no readies, init_done on edge 16.
    rst_n = 1'b1;
    push_sweep();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk("sweep_write", 32'(rf_write), 32'd1);
      chk("sweep_init_done", 32'(init_done), 32'd0);
      chk("sweep_readies", 32'({req1_ready, req0_ready}), 32'd0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("init_done_rise", 32'(init_done), 32'd1);
    chk("sweep_last_write", 32'(rf_write), 32'd1);

    // Idle ARB cycle: no write, address/data hold.
    @(negedge clk);
    chk("idle_write", 32'(rf_write), 32'd0);
    chk("idle_addr_hold", 32'(rf_addr), 32'd15);
    chk("idle_data_hold", 32'(rf_data), 32'd0);

    // Single requester 0.
    req0_valid = 1'b1; req0_addr = 4'd8; req0_data = 9'd255;
    #1 chk("single0_ready", 32'({req1_ready, req0_ready}), 32'b01);
    push(4'd8, 9'd255);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("single0_write", 32'(rf_write), 32'd1);
    chk("single0_addr", 32'(rf_addr), 32'd8);
    chk("single0_data", 32'(rf_data), 32'd255);

    // Single requester 1; pointer returns to requester 0.
    req1_valid = 1'b1; req1_addr = 4'd5; req1_data = 9'h0F0;
    #1 chk("single1_ready", 32'({req1_ready, req0_ready}), 32'b10);
    push(4'd5, 9'h0F0);
    @(negedge clk);
    req1_valid = 1'b0;

    // Continuous contention: grants alternate 0,1,0,1, write every cycle.
    req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 9'h011;
    req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 9'h122;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i % 2 == 0) begin
        chk("rr_ready", 32'({req1_ready, req0_ready}), 32'b01);
        push(4'd1, 9'h011);
      end else begin
        chk("rr_ready", 32'({req1_ready, req0_ready}), 32'b10);
        push(4'd2, 9'h122);
      end
      @(negedge clk);
      chk("rr_write", 32'(rf_write), 32'd1);
    end

    // Same address from both: 0x0AA then 0x155 on consecutive cycles.
    req0_addr = 4'd3; req0_data = 9'h0AA;
    req1_addr = 4'd3; req1_data = 9'h155;
    #1 chk("same_first", 32'({req1_ready, req0_ready}), 32'b01);
    push(4'd3, 9'h0AA);
    @(negedge clk);
    #1 chk("same_second", 32'({req1_ready, req0_ready}), 32'b10);
    push(4'd3, 9'h155);
    @(negedge clk);

    // Hold for 3 cycles: the registered write completes, then nothing.
    hold = 1'b1;
    req0_addr = 4'd6; req0_data = 9'h066;
    req1_addr = 4'd7; req1_data = 9'h177;
    chk("hold_inflight_write", 32'(rf_write), 32'd1);
    for (int j = 0; j < 3; j++) begin
      #1 chk("hold_readies", 32'({req1_ready, req0_ready}), 32'd0);
      @(negedge clk);
      chk("hold_write", 32'(rf_write), 32'd0);
      chk("hold_addr", 32'(rf_addr), 32'd3);
      chk("hold_data", 32'(rf_data), 32'h155);
    end
    hold = 1'b0;
    #1 chk("release_first", 32'({req1_ready, req0_ready}), 32'b01);
    push(4'd6, 9'h066);
    @(negedge clk);
    #1 chk("release_second", 32'({req1_ready, req0_ready}), 32'b10);
    push(4'd7, 9'h177);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("drain_write", 32'(rf_write), 32'd0);

    // Reset pulse mid-sweep at address 9.
    rst_n = 1'b0;
    #1 chk_idle_outputs("arb_reset");
    @(negedge clk);
    rst_n = 1'b1;
    push_sweep();
    repeat (10) @(negedge clk);
    chk("sweep_at_9", 32'(rf_addr), 32'd9);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1 chk_idle_outputs("sweep_reset");
    @(negedge clk);
    rst_n = 1'b1;
    push_sweep();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk("resweep_addr", 32'(rf_addr), 32'(k - 1));
      chk("resweep_init_done", 32'(init_done), 32'd0);
    end
    @(negedge clk);
    chk("resweep_init_done_rise", 32'(init_done), 32'd1);
    @(negedge clk);
    chk("final_write", 32'(rf_write), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
